// File: rtl/sccb_setup_buffer_pkg.sv
// Shared definitions for the SCCB setup buffer: state encoding, list markers
// and SCCB request field widths.
package sccb_setup_pkg;

   localparam int WORD_W      = 16;
   localparam int DEPTH       = 64;
   localparam int INDX_W      = 6;
   localparam int COUNT_W     = 7;
   localparam int SCCB_ADDR_W = 8;
   localparam int SCCB_DATA_W = 8;

   localparam logic [WORD_W-1:0]      SEQ_TERM_WORD  = 16'hFFFF;
   localparam logic [SCCB_ADDR_W-1:0] SEQ_DELAY_ADDR = 8'hFE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_DELAY,
      ST_NEXT,
      ST_FINISH
   } seq_state_e;

endpackage

// File: rtl/sccb_setup_buffer_if.sv
// Request/response channel between the setup sequencer and the SCCB master.
interface sccb_setup_buffer_if;
   import sccb_setup_pkg::*;

   logic                   sccb_valid;
   logic                   sccb_ready;
   logic [SCCB_ADDR_W-1:0] sccb_addr;
   logic [SCCB_DATA_W-1:0] sccb_data;
   logic                   sccb_done;
   logic                   sccb_nack;

   modport master (
      output sccb_valid, sccb_addr, sccb_data,
      input  sccb_ready, sccb_done, sccb_nack
   );

   modport slave (
      input  sccb_valid, sccb_addr, sccb_data,
      output sccb_ready, sccb_done, sccb_nack
   );

endinterface

// File: rtl/sccb_setup_buffer_nrst_edge_sync.sv
// Two-flop synchroniser for an asynchronous active-low trigger, followed by a
// one-cycle pulse on each synchronised falling edge.
module nrst_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_nrst_i,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Idle level of the trigger is high, so reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= async_nrst_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/sccb_setup_buffer.sv
// 64-word camera register list with host access port and a commit sequencer
// that replays the list as SCCB write requests, honouring delay entries.
module sccb_setup_buffer
   import sccb_setup_pkg::*;
#(
   parameter int                     DELAY_UNIT = 1024,
   parameter logic [WORD_W-1:0]      TERM_WORD  = SEQ_TERM_WORD,
   parameter logic [SCCB_ADDR_W-1:0] DELAY_ADDR = SEQ_DELAY_ADDR
) (
   input  logic                clk_fast,
   input  logic                g_nrst,
   input  logic                buff_port_wr,
   input  logic                buff_port_rd,
   input  logic [INDX_W-1:0]   buff_port_indx,
   input  logic [WORD_W-1:0]   buff_port_din,
   output logic [WORD_W-1:0]   buff_port_dout,
   input  logic                commit_nrst,
   sccb_setup_buffer_if.master sccb,
   output logic                busy,
   output logic                seq_done,
   output logic                seq_err,
   output logic [COUNT_W-1:0]  seq_count
);

   localparam int DIV_W = $clog2(DELAY_UNIT + 1);

   logic [WORD_W-1:0]      mem_q [DEPTH];
   logic [WORD_W-1:0]      dout_q;
   logic                   wr_en;
   logic                   commit_fall;
   logic [WORD_W-1:0]      fetch_word;

   seq_state_e             state_q;
   logic [INDX_W-1:0]      ptr_q;
   logic [7:0]             tick_q;
   logic [DIV_W-1:0]       div_q;
   logic                   valid_q;
   logic [SCCB_ADDR_W-1:0] addr_q;
   logic [SCCB_DATA_W-1:0] data_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic [COUNT_W-1:0]     count_q;

   nrst_edge_sync u_commit_sync (
      .clk          (clk_fast),
      .rst_n        (g_nrst),
      .async_nrst_i (commit_nrst),
      .fall_o       (commit_fall)
   );

   // The list is frozen while the sequencer walks it.
   assign wr_en = buff_port_wr & ~busy_q;

   always_ff @(posedge clk_fast or negedge g_nrst) begin
      if (!g_nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= TERM_WORD;
         end
      end else if (wr_en) begin
         mem_q[buff_port_indx] <= buff_port_din;
      end
   end

   always_ff @(posedge clk_fast or negedge g_nrst) begin
      if (!g_nrst) begin
         dout_q <= '0;
      end else if (buff_port_rd) begin
         dout_q <= mem_q[buff_port_indx];
      end
   end

   assign fetch_word = mem_q[ptr_q];

   always_ff @(posedge clk_fast or negedge g_nrst) begin
      if (!g_nrst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         tick_q  <= '0;
         div_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (commit_fall) begin
                  state_q <= ST_FETCH;
                  busy_q  <= 1'b1;
                  ptr_q   <= '0;
                  count_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            ST_FETCH: begin
               div_q <= '0;
               if (fetch_word == TERM_WORD) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
               end else if (fetch_word[15:8] == DELAY_ADDR) begin
                  tick_q  <= fetch_word[7:0];
                  state_q <= ST_DELAY;
               end else begin
                  addr_q  <= fetch_word[15:8];
                  data_q  <= fetch_word[7:0];
                  valid_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sccb.sccb_ready) begin
                  valid_q <= 1'b0;
                  count_q <= count_q + COUNT_W'(1);
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (sccb.sccb_done) begin
                  if (sccb.sccb_nack) begin
                     err_q <= 1'b1;
                  end
                  state_q <= ST_NEXT;
               end
            end
            ST_DELAY: begin
               // One tick per DELAY_UNIT cycles; a zero count passes straight through.
               if (tick_q == 8'd0) begin
                  state_q <= ST_NEXT;
               end else if (div_q == DIV_W'(DELAY_UNIT - 1)) begin
                  div_q  <= '0;
                  tick_q <= tick_q - 8'd1;
                  if (tick_q == 8'd1) begin
                     state_q <= ST_NEXT;
                  end
               end else begin
                  div_q <= div_q + DIV_W'(1);
               end
            end
            ST_NEXT: begin
               if (ptr_q == INDX_W'(DEPTH - 1)) begin
                  state_q <= ST_FINISH;
                  done_q  <= 1'b1;
               end else begin
                  ptr_q   <= ptr_q + INDX_W'(1);
                  state_q <= ST_FETCH;
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign buff_port_dout  = dout_q;
   assign sccb.sccb_valid = valid_q;
   assign sccb.sccb_addr  = addr_q;
   assign sccb.sccb_data  = data_q;
   assign busy            = busy_q;
   assign seq_done        = done_q;
   assign seq_err         = err_q;
   assign seq_count       = count_q;

endmodule

// File: tb/tb_sccb_setup_buffer.sv
// Directed bench for sccb_setup_buffer with a simple SCCB master responder.
module tb_sccb_setup_buffer;

   logic        clk_fast = 1'b0;
   logic        g_nrst;
   logic        buff_port_wr;
   logic        buff_port_rd;
   logic [5:0]  buff_port_indx;
   logic [15:0] buff_port_din;
   logic [15:0] buff_port_dout;
   logic        commit_nrst;
   logic        busy;
   logic        seq_done;
   logic        seq_err;
   logic [6:0]  seq_count;

   sccb_setup_buffer_if bus ();

   sccb_setup_buffer #(
      .DELAY_UNIT (4)
   ) dut (
      .clk_fast       (clk_fast),
      .g_nrst         (g_nrst),
      .buff_port_wr   (buff_port_wr),
      .buff_port_rd   (buff_port_rd),
      .buff_port_indx (buff_port_indx),
      .buff_port_din  (buff_port_din),
      .buff_port_dout (buff_port_dout),
      .commit_nrst    (commit_nrst),
      .sccb           (bus),
      .busy           (busy),
      .seq_done       (seq_done),
      .seq_err        (seq_err),
      .seq_count      (seq_count)
   );

   always #5 clk_fast = ~clk_fast;

   int vectors     = 0;
   int miscompares = 0;

   // SCCB master model: ready one cycle after valid, done three cycles later.
   logic [15:0] log_mem [512];
   int req_total  = 0;
   int done_total = 0;
   int rsp_st     = 0;
   int rsp_cnt    = 0;
   bit rsp_en     = 1'b1;
   int nack_at    = -1;

   always @(negedge clk_fast) begin
      if (!g_nrst) begin
         rsp_st         = 0;
         bus.sccb_ready = 1'b0;
         bus.sccb_done  = 1'b0;
         bus.sccb_nack  = 1'b0;
      end else begin
         case (rsp_st)
            0: begin
               bus.sccb_done = 1'b0;
               bus.sccb_nack = 1'b0;
               if (rsp_en && bus.sccb_valid === 1'b1) begin
                  bus.sccb_ready = 1'b1;
                  log_mem[req_total % 512] = {bus.sccb_addr, bus.sccb_data};
                  rsp_st = 1;
               end
            end
            1: begin
               bus.sccb_ready = 1'b0;
               rsp_cnt = 2;
               rsp_st = 2;
            end
            default: begin
               if (rsp_cnt == 0) begin
                  bus.sccb_done = 1'b1;
                  bus.sccb_nack = (req_total == nack_at);
                  req_total++;
                  rsp_st = 0;
               end else begin
                  rsp_cnt--;
               end
            end
         endcase
         if (seq_done === 1'b1) done_total++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_fast);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int idx, input logic [15:0] val);
      buff_port_indx = 6'(idx);
      buff_port_din  = val;
      buff_port_wr   = 1'b1;
      tick();
      buff_port_wr   = 1'b0;
   endtask

   task automatic host_read(input int idx);
      buff_port_indx = 6'(idx);
      buff_port_rd   = 1'b1;
      tick();
      buff_port_rd   = 1'b0;
   endtask

   task automatic run_commit(output int n);
      commit_nrst = 1'b0;
      n = 0;
      while (busy !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      commit_nrst = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy === 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic count_to_valid(output int c);
      c = 0;
      while (bus.sccb_valid !== 1'b1 && c < 200) begin
         tick();
         c++;
      end
   endtask

   int n_lat;
   int base_req;
   int base_done;
   int c_delay;
   int c_zero;

   initial begin
      g_nrst         = 1'b0;
      commit_nrst    = 1'b1;
      buff_port_wr   = 1'b0;
      buff_port_rd   = 1'b0;
      buff_port_indx = '0;
      buff_port_din  = '0;
      tick(3);

      check("rst_dout",  32'(buff_port_dout), 32'h0);
      check("rst_valid", 32'(bus.sccb_valid), 32'h0);
      check("rst_addr",  32'(bus.sccb_addr),  32'h0);
      check("rst_data",  32'(bus.sccb_data),  32'h0);
      check("rst_busy",  32'(busy),           32'h0);
      check("rst_done",  32'(seq_done),       32'h0);
      check("rst_err",   32'(seq_err),        32'h0);
      check("rst_count", 32'(seq_count),      32'h0);
      g_nrst = 1'b1;
      tick(2);

      // Basic two-entry list
      host_write(0, 16'h1280);
      host_write(1, 16'h1101);
      host_write(2, 16'hFFFF);
      base_req  = req_total;
      base_done = done_total;
      run_commit(n_lat);
      check("commit_latency", 32'(n_lat), 32'd3);
      wait_idle("basic_timeout", 300);
      tick(2);
      check("basic_reqs",  32'(req_total - base_req), 32'd2);
      check("basic_req0",  32'(log_mem[base_req % 512]), 32'h1280);
      check("basic_req1",  32'(log_mem[(base_req + 1) % 512]), 32'h1101);
      check("basic_count", 32'(seq_count), 32'd2);
      check("basic_err",   32'(seq_err), 32'd0);
      check("basic_donep", 32'(done_total - base_done), 32'd1);

      // Host port reads
      host_write(5, 16'hABCD);
      host_read(5);
      check("read_idx5", 32'(buff_port_dout), 32'hABCD);
      host_read(9);
      check("read_unwritten", 32'(buff_port_dout), 32'hFFFF);
      buff_port_indx = 6'd5;
      buff_port_din  = 16'h1234;
      buff_port_wr   = 1'b1;
      buff_port_rd   = 1'b1;
      tick();
      buff_port_wr   = 1'b0;
      buff_port_rd   = 1'b0;
      check("rdwr_old", 32'(buff_port_dout), 32'hABCD);
      tick(2);
      check("dout_hold", 32'(buff_port_dout), 32'hABCD);
      host_read(5);
      check("rdwr_new", 32'(buff_port_dout), 32'h1234);

      // Delay entry of 3 ticks versus 0 ticks
      host_write(0, 16'hFE03);
      host_write(1, 16'h1280);
      host_write(2, 16'hFFFF);
      base_req = req_total;
      run_commit(n_lat);
      count_to_valid(c_delay);
      wait_idle("delay3_timeout", 300);
      host_write(0, 16'hFE00);
      run_commit(n_lat);
      count_to_valid(c_zero);
      wait_idle("delay0_timeout", 300);
      tick(2);
      check("delay_reqs",  32'(req_total - base_req), 32'd2);
      check("delay_count", 32'(seq_count), 32'd1);
      check("delay_span_ok", 32'((c_delay - c_zero) >= 11 && (c_delay - c_zero) <= 13), 32'd1);
      check("delay0_fast", 32'(c_zero <= 5), 32'd1);

      // NACK on first of three entries
      host_write(0, 16'h1280);
      host_write(1, 16'h1101);
      host_write(2, 16'h1300);
      host_write(3, 16'hFFFF);
      base_req = req_total;
      nack_at  = req_total;
      run_commit(n_lat);
      wait_idle("nack_timeout", 300);
      nack_at = -1;
      tick(5);
      check("nack_reqs",  32'(req_total - base_req), 32'd3);
      check("nack_req2",  32'(log_mem[(base_req + 2) % 512]), 32'h1300);
      check("nack_err",   32'(seq_err), 32'd1);
      check("nack_count", 32'(seq_count), 32'd3);

      // Full list, no terminator: 64 requests, stray commit and write ignored
      for (int i = 0; i < 64; i++) host_write(i, 16'h2000 | 16'(i));
      base_req  = req_total;
      base_done = done_total;
      run_commit(n_lat);
      check("full_err_clr", 32'(seq_err), 32'd0);
      tick(8);
      commit_nrst = 1'b0;
      host_write(0, 16'hFFFF);
      wait_idle("full_timeout", 3000);
      tick(10);
      check("full_reqs",  32'(req_total - base_req), 32'd64);
      check("full_first", 32'(log_mem[base_req % 512]), 32'h2000);
      check("full_last",  32'(log_mem[(base_req + 63) % 512]), 32'h203F);
      check("full_count", 32'(seq_count), 32'd64);
      check("full_donep", 32'(done_total - base_done), 32'd1);
      check("full_recommit_ign", 32'(busy), 32'd0);
      host_read(0);
      check("full_wr_dropped", 32'(buff_port_dout), 32'h2000);
      commit_nrst = 1'b1;
      tick(4);

      // Reset while stalled in ISSUE
      rsp_en = 1'b0;
      run_commit(n_lat);
      count_to_valid(c_zero);
      tick(2);
      check("stall_valid", 32'(bus.sccb_valid), 32'd1);
      #2;
      g_nrst = 1'b0;
      #1;
      check("arst_valid", 32'(bus.sccb_valid), 32'd0);
      check("arst_busy",  32'(busy),           32'd0);
      check("arst_count", 32'(seq_count),      32'd0);
      check("arst_addr",  32'(bus.sccb_addr),  32'd0);
      check("arst_dout",  32'(buff_port_dout), 32'd0);
      tick(2);
      g_nrst = 1'b1;
      rsp_en = 1'b1;
      tick(2);
      host_read(0);
      check("arst_mem0", 32'(buff_port_dout), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
